// File: rtl/ysyx_23060236_div_iter_if.sv
// Request/response bundle between the execute unit (master) and the divider (slave).
// Handshake: a request is accepted on a rising edge where div_valid and div_ready are both high;
// div_ready never depends on div_valid, and div_outvalid marks the single cycle res/rem are new.
interface ysyx_23060236_div_iter_if;
  logic        div_valid;
  logic        div_ready;
  logic        div_sign;
  logic [31:0] div1;
  logic [31:0] div2;
  logic [31:0] res;
  logic [31:0] rem;
  logic        div_outvalid;

  modport master (
    output div_valid, div_sign, div1, div2,
    input  div_ready, res, rem, div_outvalid
  );

  modport slave (
    input  div_valid, div_sign, div1, div2,
    output div_ready, res, rem, div_outvalid
  );
endinterface

// File: rtl/ysyx_23060236_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional YSYX_23060236_DIV_EARLY_OUT_EN: trivial cases finish one cycle after accept.
module ysyx_23060236_div_iter (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_23060236_div_iter_if.slave       div,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] dvd_q;
  logic [31:0] prem_q;
  logic [31:0] bmag_q;
  logic [31:0] dvd_orig_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        bzero_q;
  logic        ovf_q;
  logic [4:0]  cnt_q;
  logic [31:0] res_q;
  logic [31:0] rem_q;

  logic        accept;
  logic        last_iter;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] amag_in;
  logic [31:0] bmag_in;
  logic        bzero_in;
  logic        ovf_in;
  logic        early_in;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] prem_nxt;
  logic [31:0] dvd_nxt;
  logic [31:0] fin_res;
  logic [31:0] fin_rem;

  assign accept    = (state == IDLE) && div.div_valid;
  assign last_iter = (state == BUSY) && (cnt_q == 5'd31);

  // Operand conditioning on the request side, used only in the accept cycle.
  always_comb begin
    a_neg_in = div.div_sign & div.div1[31];
    b_neg_in = div.div_sign & div.div2[31];
    amag_in  = a_neg_in ? (~div.div1 + 32'd1) : div.div1;
    bmag_in  = b_neg_in ? (~div.div2 + 32'd1) : div.div2;
    bzero_in = (div.div2 == 32'd0);
    ovf_in   = div.div_sign && (div.div1 == 32'h8000_0000) && (div.div2 == 32'hFFFF_FFFF);
  end

`ifdef YSYX_23060236_DIV_EARLY_OUT_EN
  logic [31:0] early_res;
  logic [31:0] early_rem;
  always_comb begin
    early_in  = bzero_in | ovf_in | (amag_in < bmag_in);
    early_res = bzero_in ? 32'hFFFF_FFFF : (ovf_in ? 32'h8000_0000 : 32'd0);
    early_rem = ovf_in ? 32'd0 : div.div1;
  end
`else
  assign early_in = 1'b0;
`endif

  // One restoring step: remainder gains the next dividend MSB, quotient bit shifts in at the LSB.
  always_comb begin
    shifted  = {prem_q, dvd_q[31]};
    diff     = shifted - {1'b0, bmag_q};
    q_bit    = ~diff[32];
    prem_nxt = q_bit ? diff[31:0] : shifted[31:0];
    dvd_nxt  = {dvd_q[30:0], q_bit};
  end

  always_comb begin
    if (bzero_q) begin
      fin_res = 32'hFFFF_FFFF;
      fin_rem = dvd_orig_q;
    end else if (ovf_q) begin
      fin_res = 32'h8000_0000;
      fin_rem = 32'd0;
    end else begin
      fin_res = q_neg_q ? (~dvd_nxt + 32'd1) : dvd_nxt;
      fin_rem = r_neg_q ? (~prem_nxt + 32'd1) : prem_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early_in ? DONE : BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div.div_ready    = (state == IDLE);
    div.div_outvalid = (state == DONE);
    div.res          = res_q;
    div.rem          = rem_q;
    dbg_state        = state;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      dvd_q      <= 32'd0;
      prem_q     <= 32'd0;
      bmag_q     <= 32'd0;
      dvd_orig_q <= 32'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      bzero_q    <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= 5'd0;
      res_q      <= 32'd0;
      rem_q      <= 32'd0;
    end else if (accept) begin
      dvd_q      <= amag_in;
      prem_q     <= 32'd0;
      bmag_q     <= bmag_in;
      dvd_orig_q <= div.div1;
      q_neg_q    <= a_neg_in ^ b_neg_in;
      r_neg_q    <= a_neg_in;
      bzero_q    <= bzero_in;
      ovf_q      <= ovf_in;
      cnt_q      <= 5'd0;
`ifdef YSYX_23060236_DIV_EARLY_OUT_EN
      if (early_in) begin
        res_q <= early_res;
        rem_q <= early_rem;
      end
`endif
    end else if (state == BUSY) begin
      dvd_q  <= dvd_nxt;
      prem_q <= prem_nxt;
      cnt_q  <= cnt_q + 5'd1;
      if (last_iter) begin
        res_q <= fin_res;
        rem_q <= fin_rem;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_div_iter.sv
// Self-checking bench for ysyx_23060236_div_iter: directed cases plus randomized operands
// against an arithmetic reference model of RV32M division.
module tb_ysyx_23060236_div_iter;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;
  int         tests;
  int         fails;

  ysyx_23060236_div_iter_if bus ();

  ysyx_23060236_div_iter dut (
    .clock     (clock),
    .reset     (reset),
    .div       (bus),
    .dbg_state (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef YSYX_23060236_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  // Reference: RISC-V division semantics plus the expected response latency.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        ma;
    logic [31:0]        mb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (ovf) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    ma  = (s && a[31]) ? -a : a;
    mb  = (s && b[31]) ? -b : b;
    lat = ((b == 0) || ovf || (ma < mb)) ? EARLY_LAT : 33;
  endfunction

  // Presents one request, then waits (bounded) for the response pulse.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] got_res, output logic [31:0] got_rem,
                        output int lat, output int rdy_hi, output logic rdy_at_req);
    @(negedge clock);
    bus.div_valid = 1'b1;
    bus.div_sign  = s;
    bus.div1      = a;
    bus.div2      = b;
    rdy_at_req    = bus.div_ready;
    @(posedge clock);
    @(negedge clock);
    bus.div_valid = 1'b0;
    bus.div1      = $urandom;
    bus.div2      = $urandom;
    bus.div_sign  = 1'($urandom);
    lat     = -1;
    rdy_hi  = 0;
    got_res = 32'd0;
    got_rem = 32'd0;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) @(negedge clock);
      if (bus.div_outvalid) begin
        lat     = k;
        got_res = bus.res;
        got_rem = bus.rem;
        break;
      end
      if (bus.div_ready) rdy_hi++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    tests++; if (bus.div_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.div_ready); end
    tests++; if (bus.div_outvalid !== 1'b0) begin fails++; $display("FAIL reset_outvalid got=%b exp=0", bus.div_outvalid); end
    tests++; if (bus.res !== 32'd0) begin fails++; $display("FAIL reset_res got=%h exp=0", bus.res); end
    tests++; if (bus.rem !== 32'd0) begin fails++; $display("FAIL reset_rem got=%h exp=0", bus.rem); end
    tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_unsigned();
    logic [31:0] r, m; int lat, rh; logic ra;
    do_txn(32'd100, 32'd7, 1'b0, r, m, lat, rh, ra);
    tests++; if (ra !== 1'b1) begin fails++; $display("FAIL udiv_ready_at_req got=%b exp=1", ra); end
    tests++; if (r !== 32'd14) begin fails++; $display("FAIL udiv_res got=%0d exp=14", r); end
    tests++; if (m !== 32'd2) begin fails++; $display("FAIL udiv_rem got=%0d exp=2", m); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL udiv_latency got=%0d exp=33", lat); end
    tests++; if (rh !== 0) begin fails++; $display("FAIL udiv_ready_busy got=%0d high cycles exp=0", rh); end
    @(negedge clock);
    tests++; if (bus.div_outvalid !== 1'b0) begin fails++; $display("FAIL udiv_pulse_width got=%b exp=0", bus.div_outvalid); end
    tests++; if (bus.div_ready !== 1'b1) begin fails++; $display("FAIL udiv_ready_after got=%b exp=1", bus.div_ready); end
    tests++; if (bus.res !== 32'd14 || bus.rem !== 32'd2) begin fails++; $display("FAIL udiv_hold got=%0d/%0d exp=14/2", bus.res, bus.rem); end
  endtask

  task automatic test_signed();
    logic [31:0] r, m; int lat, rh; logic ra;
    do_txn(32'hFFFF_FFF9, 32'd2, 1'b1, r, m, lat, rh, ra);
    tests++; if (r !== 32'hFFFF_FFFD || m !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sdiv_neg7_2 got=%h/%h exp=fffffffd/ffffffff", r, m); end
    tests++; if (lat !== 33) begin fails++; $display("FAIL sdiv_neg7_2_latency got=%0d exp=33", lat); end
    do_txn(32'd7, 32'hFFFF_FFFE, 1'b1, r, m, lat, rh, ra);
    tests++; if (r !== 32'hFFFF_FFFD || m !== 32'd1) begin fails++; $display("FAIL sdiv_7_neg2 got=%h/%h exp=fffffffd/00000001", r, m); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r, m; int lat, rh; logic ra;
    for (int s = 0; s < 2; s++) begin
      do_txn(32'd5, 32'd0, 1'(s), r, m, lat, rh, ra);
      tests++; if (r !== 32'hFFFF_FFFF || m !== 32'd5) begin fails++; $display("FAIL divzero_s%0d got=%h/%h exp=ffffffff/00000005", s, r, m); end
      tests++; if (lat !== EARLY_LAT) begin fails++; $display("FAIL divzero_s%0d_latency got=%0d exp=%0d", s, lat, EARLY_LAT); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r, m; int lat, rh; logic ra;
    do_txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, m, lat, rh, ra);
    tests++; if (r !== 32'h8000_0000 || m !== 32'd0) begin fails++; $display("FAIL overflow got=%h/%h exp=80000000/00000000", r, m); end
    tests++; if (lat !== EARLY_LAT) begin fails++; $display("FAIL overflow_latency got=%0d exp=%0d", lat, EARLY_LAT); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r, m; int lat, rh; logic ra; int pulses;
    pulses = 0;
    @(negedge clock);
    bus.div_valid = 1'b1; bus.div_sign = 1'b0; bus.div1 = 32'd1000; bus.div2 = 32'd3;
    @(posedge clock);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) bus.div_valid = 1'b0;
      if (bus.div_outvalid) pulses++;
    end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tests++; if (bus.div_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got=%b exp=1", bus.div_ready); end
    tests++; if (bus.res !== 32'd0 || bus.rem !== 32'd0) begin fails++; $display("FAIL abort_outputs got=%h/%h exp=0/0", bus.res, bus.rem); end
    for (int k = 0; k < 40; k++) begin
      if (bus.div_outvalid) pulses++;
      @(negedge clock);
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_pulse got=%0d pulses exp=0", pulses); end
    do_txn(32'd9, 32'd3, 1'b0, r, m, lat, rh, ra);
    tests++; if (r !== 32'd3 || m !== 32'd0) begin fails++; $display("FAIL abort_next got=%0d/%0d exp=3/0", r, m); end
  endtask

  task automatic test_back_to_back();
    int first, second, hold_bad;
    first = -1; second = -1; hold_bad = 0;
    @(negedge clock);
    bus.div_valid = 1'b1; bus.div_sign = 1'b0; bus.div1 = 32'd1000; bus.div2 = 32'd7;
    @(posedge clock);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (k == 1) begin bus.div1 = 32'd12345; bus.div2 = 32'd100; end
      if (bus.div_outvalid) begin
        if (first < 0) begin
          first = k;
          tests++; if (bus.res !== 32'd142 || bus.rem !== 32'd6) begin fails++; $display("FAIL b2b_first got=%0d/%0d exp=142/6", bus.res, bus.rem); end
        end else begin
          second = k;
          tests++; if (bus.res !== 32'd123 || bus.rem !== 32'd45) begin fails++; $display("FAIL b2b_second got=%0d/%0d exp=123/45", bus.res, bus.rem); end
          break;
        end
      end else if (first > 0 && (bus.res !== 32'd142 || bus.rem !== 32'd6)) begin
        hold_bad++;
      end
    end
    bus.div_valid = 1'b0;
    tests++; if (first !== 33) begin fails++; $display("FAIL b2b_first_latency got=%0d exp=33", first); end
    tests++; if (second !== 67) begin fails++; $display("FAIL b2b_second_latency got=%0d exp=67", second); end
    tests++; if (hold_bad !== 0) begin fails++; $display("FAIL b2b_hold got=%0d bad cycles exp=0", hold_bad); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, m, er, em; logic s, ra; int lat, rh, el;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 50);
        2: a = -$urandom_range(1, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      model(a, b, s, er, em, el);
      do_txn(a, b, s, r, m, lat, rh, ra);
      tests++; if (r !== er || m !== em) begin fails++; $display("FAIL rand_%0d a=%h b=%h s=%b got=%h/%h exp=%h/%h", i, a, b, s, r, m, er, em); end
      tests++; if (lat !== el) begin fails++; $display("FAIL rand_%0d_latency got=%0d exp=%0d", i, lat, el); end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0;
    bus.div_valid = 1'b0; bus.div_sign = 1'b0; bus.div1 = 32'd0; bus.div2 = 32'd0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
